// File: rtl/alu_pkg.sv
// Shared ALU board constants: bus widths and the meaning of each load button.
package alu_pkg;

   localparam int SIZEDATA   = 8;
   localparam int N_BUTTONS  = 3;
   localparam int OPCODE_W   = 6;

   localparam int BTN_DATA_A = 0;
   localparam int BTN_DATA_B = 1;
   localparam int BTN_OPCODE = 2;

endpackage

// File: rtl/debounce_cell.sv
// One push-button debouncer: 2-flop synchronizer, stability counter, and the
// debounced level. 'rise' is high during the cycle whose closing edge turns
// the debounced level from 0 to 1, so the parent can latch a pending flag on
// that very edge.
module debounce_cell #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clock,
   input  logic reset,
   input  logic rawIn,
   output logic rise
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1;
   logic          sync2;
   logic          stableLevel;
   logic [CW-1:0] count;

   // Two flops bring the asynchronous button level into the clock domain
   // before anything looks at it.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= rawIn;
         sync2 <= sync1;
      end
   end

   // The counter measures how long the synchronized level has disagreed with
   // the debounced level; any agreement restarts it, so a bounce train never
   // accumulates. Once the disagreement has lasted DEBOUNCE_CYCLES cycles the
   // new level is accepted.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stableLevel <= 1'b0;
         count       <= '0;
      end else if (sync2 == stableLevel) begin
         count <= '0;
      end else if (count == LAST) begin
         stableLevel <= sync2;
         count       <= '0;
      end else begin
         count <= count + CW'(1);
      end
   end

   // Only a press (0 to 1) is reported; releases are debounced silently.
   always_comb begin
      rise = sync2 & ~stableLevel & (count == LAST);
   end

endmodule

// File: rtl/button_conditioner.sv
// Conditions the board switches and push-buttons for the ALU: every button is
// debounced, each accepted press becomes a single one-cycle load strobe, and
// the switch value is captured on the same edge so the ALU sees matching data.
module button_conditioner #(
   parameter int SIZEDATA        = alu_pkg::SIZEDATA,
   parameter int N_BUTTONS       = alu_pkg::N_BUTTONS,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic [SIZEDATA-1:0]  SWITCHES_IN,
   input  logic [N_BUTTONS-1:0] BUTTONS_IN,
   output logic [SIZEDATA-1:0]  SWITCHES_OUT,
   output logic [N_BUTTONS-1:0] BUTTONS_OUT
);

   logic [SIZEDATA-1:0]  swSync1;
   logic [SIZEDATA-1:0]  swSync2;
   logic [N_BUTTONS-1:0] riseBus;
   logic [N_BUTTONS-1:0] pending;
   logic [N_BUTTONS-1:0] grant;

   for (genvar i = 0; i < N_BUTTONS; i++) begin : g_cell
      debounce_cell #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_cell (
         .clock(CLK),
         .reset(RESET),
         .rawIn(BUTTONS_IN[i]),
         .rise (riseBus[i])
      );
   end

   // The switches get the same two-flop treatment as the buttons so the value
   // captured with a strobe is never metastable.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         swSync1 <= '0;
         swSync2 <= '0;
      end else begin
         swSync1 <= SWITCHES_IN;
         swSync2 <= swSync1;
      end
   end

   // Isolating the lowest set bit of the pending mask (x & -x) gives the
   // fixed-priority grant; it is all zeros whenever nothing is pending.
   always_comb begin
      grant = pending & (~pending + N_BUTTONS'(1));
   end

   // Pending flags remember accepted presses until they are issued, one per
   // cycle in ascending index order. A flag that is set again while already
   // pending simply stays set, so a press is never counted twice. The switch
   // snapshot is taken only on cycles that issue a strobe and held otherwise.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         pending      <= '0;
         BUTTONS_OUT  <= '0;
         SWITCHES_OUT <= '0;
      end else begin
         pending     <= (pending & ~grant) | riseBus;
         BUTTONS_OUT <= grant;
         if (|pending) begin
            SWITCHES_OUT <= swSync2;
         end
      end
   end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with a short debounce window.
// Timing reference: inputs change 1 ns after a rising edge, so the next
// rising edge is "edge 0"; the loops sample 1 ns after each edge.
module tb_button_conditioner;

   localparam int SIZEDATA = 8;
   localparam int NBTN     = 3;
   localparam int DEBOUNCE = 4;

   logic                CLK;
   logic                RESET;
   logic [SIZEDATA-1:0] SWITCHES_IN;
   logic [NBTN-1:0]     BUTTONS_IN;
   logic [SIZEDATA-1:0] SWITCHES_OUT;
   logic [NBTN-1:0]     BUTTONS_OUT;

   int testsRun = 0;
   int failures = 0;

   logic [7:0] regA;
   logic [7:0] regB;
   logic [5:0] regOp;

   button_conditioner #(
      .SIZEDATA       (SIZEDATA),
      .N_BUTTONS      (NBTN),
      .DEBOUNCE_CYCLES(DEBOUNCE)
   ) dut (
      .CLK         (CLK),
      .RESET       (RESET),
      .SWITCHES_IN (SWITCHES_IN),
      .BUTTONS_IN  (BUTTONS_IN),
      .SWITCHES_OUT(SWITCHES_OUT),
      .BUTTONS_OUT (BUTTONS_OUT)
   );

   // 20 ns free-running clock.
   initial begin
      CLK = 1'b0;
      forever #10 CLK = ~CLK;
   end

   // Advance to 1 ns after the next rising edge.
   task automatic waitCycle();
      @(posedge CLK);
      #1;
   endtask

   task automatic waitCycles(input int n);
      for (int k = 0; k < n; k++) waitCycle();
   endtask

   // Drive the raw board inputs.
   task automatic applyStimulus(input logic [NBTN-1:0] btn, input logic [SIZEDATA-1:0] sw);
      BUTTONS_IN  = btn;
      SWITCHES_IN = sw;
   endtask

   // Reset held for one cycle while the inputs toggle; outputs must stay 0.
   task automatic test_reset();
      RESET = 1'b1;
      applyStimulus(3'b111, 8'hFF);
      #1;
      testsRun++;
      if (BUTTONS_OUT !== 3'b000 || SWITCHES_OUT !== 8'h00) begin
         failures++;
         $display("[TB] FAIL reset_start: got btn=%b sw=%h, expected btn=000 sw=00", BUTTONS_OUT, SWITCHES_OUT);
      end
      @(negedge CLK);
      applyStimulus(3'b010, 8'h5A);
      #1;
      testsRun++;
      if (BUTTONS_OUT !== 3'b000 || SWITCHES_OUT !== 8'h00) begin
         failures++;
         $display("[TB] FAIL reset_toggle: got btn=%b sw=%h, expected btn=000 sw=00", BUTTONS_OUT, SWITCHES_OUT);
      end
      waitCycle();
      testsRun++;
      if (BUTTONS_OUT !== 3'b000 || SWITCHES_OUT !== 8'h00) begin
         failures++;
         $display("[TB] FAIL reset_edge: got btn=%b sw=%h, expected btn=000 sw=00", BUTTONS_OUT, SWITCHES_OUT);
      end
      RESET = 1'b0;
      applyStimulus(3'b000, 8'h00);
      for (int c = 0; c < 8; c++) begin
         waitCycle();
         testsRun++;
         if (BUTTONS_OUT !== 3'b000 || SWITCHES_OUT !== 8'h00) begin
            failures++;
            $display("[TB] FAIL reset_after c%0d: got btn=%b sw=%h, expected btn=000 sw=00", c, BUTTONS_OUT, SWITCHES_OUT);
         end
      end
   endtask

   // Clean press on bit0 held 30 cycles: one strobe after edge 6 with A5.
   task automatic test_clean_press();
      logic [NBTN-1:0] expBtn;
      applyStimulus(3'b000, 8'hA5);
      waitCycles(4);
      applyStimulus(3'b001, 8'hA5);
      for (int e = 0; e < 30; e++) begin
         waitCycle();
         expBtn = (e == 6) ? 3'b001 : 3'b000;
         testsRun++;
         if (BUTTONS_OUT !== expBtn) begin
            failures++;
            $display("[TB] FAIL clean_press edge%0d: got %b, expected %b", e, BUTTONS_OUT, expBtn);
         end
         if (e == 6) begin
            testsRun++;
            if (SWITCHES_OUT !== 8'hA5) begin
               failures++;
               $display("[TB] FAIL clean_press_sw: got %h, expected a5", SWITCHES_OUT);
            end
         end
         if (e == 10) SWITCHES_IN = 8'h3C;
      end
      testsRun++;
      if (SWITCHES_OUT !== 8'hA5) begin
         failures++;
         $display("[TB] FAIL switch_hold: got %h, expected a5", SWITCHES_OUT);
      end
      applyStimulus(3'b000, 8'h3C);
      for (int c = 0; c < 12; c++) begin
         waitCycle();
         testsRun++;
         if (BUTTONS_OUT !== 3'b000) begin
            failures++;
            $display("[TB] FAIL release c%0d: got %b, expected 000", c, BUTTONS_OUT);
         end
      end
   endtask

   // Bit1 bounces 3 high / 2 low / 3 high: never long enough to qualify.
   task automatic test_glitch();
      logic [NBTN-1:0] pattern [8];
      pattern = '{3'b010, 3'b010, 3'b010, 3'b000, 3'b000, 3'b010, 3'b010, 3'b010};
      for (int c = 0; c < 8; c++) begin
         BUTTONS_IN = pattern[c];
         waitCycle();
         testsRun++;
         if (BUTTONS_OUT !== 3'b000) begin
            failures++;
            $display("[TB] FAIL glitch c%0d: got %b, expected 000", c, BUTTONS_OUT);
         end
      end
      BUTTONS_IN = 3'b000;
      for (int c = 0; c < 12; c++) begin
         waitCycle();
         testsRun++;
         if (BUTTONS_OUT !== 3'b000) begin
            failures++;
            $display("[TB] FAIL glitch_tail c%0d: got %b, expected 000", c, BUTTONS_OUT);
         end
      end
   endtask

   // Bits 0 and 2 together: 001 after edge 6, 100 after edge 7.
   task automatic test_simultaneous();
      logic [NBTN-1:0] expBtn;
      applyStimulus(3'b101, 8'h11);
      for (int e = 0; e < 14; e++) begin
         waitCycle();
         expBtn = (e == 6) ? 3'b001 : (e == 7) ? 3'b100 : 3'b000;
         testsRun++;
         if (BUTTONS_OUT !== expBtn) begin
            failures++;
            $display("[TB] FAIL simultaneous edge%0d: got %b, expected %b", e, BUTTONS_OUT, expBtn);
         end
      end
      applyStimulus(3'b000, 8'h11);
      waitCycles(12);
   endtask

   // Reset pulsed at edge 3 of a bit2 press: count discarded, full latency after.
   task automatic test_reset_mid_count();
      logic [NBTN-1:0] expBtn;
      applyStimulus(3'b100, 8'h22);
      waitCycles(3);
      RESET = 1'b1;
      #1;
      testsRun++;
      if (BUTTONS_OUT !== 3'b000 || SWITCHES_OUT !== 8'h00) begin
         failures++;
         $display("[TB] FAIL mid_reset_async: got btn=%b sw=%h, expected btn=000 sw=00", BUTTONS_OUT, SWITCHES_OUT);
      end
      waitCycle();
      RESET = 1'b0;
      for (int e = 0; e < 12; e++) begin
         waitCycle();
         expBtn = (e == 6) ? 3'b100 : 3'b000;
         testsRun++;
         if (BUTTONS_OUT !== expBtn) begin
            failures++;
            $display("[TB] FAIL mid_reset edge%0d: got %b, expected %b", e, BUTTONS_OUT, expBtn);
         end
      end
      applyStimulus(3'b000, 8'h22);
      waitCycles(12);
   endtask

   // Press one load button with a switch value and let the bench ALU latch it.
   task automatic pressButton(input int idx, input logic [7:0] sw);
      int waited;
      logic [NBTN-1:0] expBtn;
      expBtn = 3'b001 << idx;
      applyStimulus(3'b000, sw);
      waitCycles(3);
      applyStimulus(expBtn, sw);
      waited = 0;
      while (BUTTONS_OUT === 3'b000 && waited < 40) begin
         waitCycle();
         waited++;
      end
      testsRun++;
      if (BUTTONS_OUT !== expBtn) begin
         failures++;
         $display("[TB] FAIL alu_strobe%0d: got %b, expected %b", idx, BUTTONS_OUT, expBtn);
      end else begin
         case (idx)
            0:       regA  = SWITCHES_OUT;
            1:       regB  = SWITCHES_OUT;
            default: regOp = SWITCHES_OUT[5:0];
         endcase
      end
      applyStimulus(3'b000, sw);
      waitCycles(12);
   endtask

   // A=05, B=03, OPCODE=100000 (add) must light LEDS=08.
   task automatic test_alu_end_to_end();
      logic [7:0] leds;
      regA  = 8'h00;
      regB  = 8'h00;
      regOp = 6'b000000;
      pressButton(alu_pkg::BTN_DATA_A, 8'h05);
      pressButton(alu_pkg::BTN_DATA_B, 8'h03);
      pressButton(alu_pkg::BTN_OPCODE, 8'h20);
      leds = (regOp == 6'b100000) ? regA + regB : 8'h00;
      testsRun++;
      if (leds !== 8'h08) begin
         failures++;
         $display("[TB] FAIL alu_leds: got %h, expected 08", leds);
      end
   endtask

   // Run every scenario in order and report.
   initial begin
      RESET = 1'b0;
      applyStimulus(3'b000, 8'h00);
      test_reset();
      test_clean_press();
      test_glitch();
      test_simultaneous();
      test_reset_mid_count();
      test_alu_end_to_end();
      $display("[TB] %0d tests run, %0d failed", testsRun, failures);
      $finish;
   end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 SHALL have parameter SIZEDATA, default 8, width of the switch bus.
REQ-002 SHALL have parameter N_BUTTONS, default 3, number of push-buttons.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 500000 (10 ms at 50 MHz), minimum 1.
REQ-004 SHALL have port CLK  input  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port SWITCHES_IN  input  SIZEDATA  raw board switches.
REQ-007 SHALL have port BUTTONS_IN  input  N_BUTTONS  raw, bouncing push-buttons.
REQ-008 SHALL have port SWITCHES_OUT  output  SIZEDATA  switch value captured with the current strobe; feeds ALU SWITCHES.
REQ-009 SHALL have port BUTTONS_OUT  output  N_BUTTONS  one-cycle, one-hot load strobes; feeds ALU BUTTONS (bit0 DATA A, bit1 DATA B, bit2 OPCODE).

Function
REQ-010 SHALL pass each BUTTONS_IN bit and the SWITCHES_IN bus through a 2-flop synchronizer.
REQ-011 SHALL keep, per button, a debounced stable level and a counter of width clog2(DEBOUNCE_CYCLES+1).
REQ-012 SHALL clear the counter on every cycle the synchronized level equals the stable level.
REQ-013 SHALL increment the counter on every cycle the synchronized level differs from the stable level.
REQ-014 SHALL update the stable level and clear the counter on the edge where the counter equals DEBOUNCE_CYCLES-1 and the levels still differ.
REQ-015 SHALL raise a per-button pending flag when the stable level changes from 0 to 1; a 1-to-0 change SHALL NOT raise it.
REQ-016 SHALL, each cycle any flag is pending, drive BUTTONS_OUT for one cycle with only the lowest-indexed pending bit set, and clear that flag.
REQ-017 SHALL, on the same edge that drives a strobe, load SWITCHES_OUT from the synchronized switches; SWITCHES_OUT SHALL hold otherwise.
REQ-018 SHALL drive BUTTONS_OUT to zero on every cycle no flag is pending; both outputs SHALL be registered.
REQ-019 SHALL time strobes from an isolated clean press, taking the edge that first samples the new raw level as edge 0: stable updates at edge DEBOUNCE_CYCLES+1 and BUTTONS_OUT is high after edge DEBOUNCE_CYCLES+2.
REQ-020 SHALL produce exactly one strobe per debounced press, however long the button is held.
REQ-021 SHALL produce no strobe for a raw pulse, or any bounce train, shorter than DEBOUNCE_CYCLES synchronized cycles.
REQ-022 SHALL emit presses that qualify on the same cycle on consecutive cycles in ascending index order; BUTTONS_OUT SHALL never have more than one bit set.
REQ-023 SHALL, if a button re-qualifies while its flag is already pending, keep a single pending flag (no counting).

Reset
REQ-024 SHALL, while RESET is high, clear synchronizers, stable levels, counters, pending flags, SWITCHES_OUT (0) and BUTTONS_OUT (0) asynchronously.
REQ-025 SHALL discard any debounce count in progress on a reset mid-operation.
REQ-026 SHALL, after reset release with a button still held, debounce that button from zero and issue one strobe at full latency.

Structure
REQ-027 SHALL take SIZEDATA, N_BUTTONS and the button index constants BTN_DATA_A=0, BTN_DATA_B=1 and BTN_OPCODE=2 from the shared alu_pkg package.
REQ-028 SHALL contain one sub-module, debounce_cell (synchronizer, counter, stable level, rise flag), instantiated N_BUTTONS times by generate.
REQ-029 SHALL keep the pending mask, priority selection and switch capture in the top module.

Verification (DEBOUNCE_CYCLES=4, 20 ns clock)
REQ-030 SHALL check reset: RESET high for 1 cycle with inputs toggling -> SWITCHES_OUT=8'h00 and BUTTONS_OUT=3'b000 throughout.
REQ-031 SHALL check a clean press: SWITCHES_IN=8'hA5, BUTTONS_IN bit0 held 30 cycles -> a single BUTTONS_OUT=3'b001 pulse after edge 6 with SWITCHES_OUT=8'hA5, then 3'b000.
REQ-032 SHALL check glitch rejection: bit1 high 3 cycles, low 2, high 3, then low -> BUTTONS_OUT stays 3'b000.
REQ-033 SHALL check simultaneous presses: bits 0 and 2 rise on the same edge -> 3'b001 then 3'b100 on the next cycle, never 3'b101.
REQ-034 SHALL check reset mid-count: bit2 pressed, RESET pulsed at edge 3, bit2 still held -> no early pulse; 3'b100 arrives at full latency after release of RESET.
REQ-035 SHALL run the ALU_top end-to-end sequence (A=8'h05, B=8'h03, OPCODE=6'b100000) through this block -> LEDS=8'h08.
